inst_fetch_resp: RTL and testbench

Instruction-side responder for the fetch stage. Accepts the fetch address (pc) and chip enable (ce) from the PC register and returns the instruction word. Serves hits from a single-line fetch buffer. On a miss it raises stallreq, which the pipeline controller turns into stall[0]. It then refills the whole line from backing memory over a req/ack handshake. It sits between the PC register and the instruction bus.

---
 rtl/inst_fetch_resp.sv | 182 ++++++++++++++++++
 tb/tb_inst_fetch_resp.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_resp.sv
`default_nettype none
// ============================================================================
// Module : inst_fetch_resp
// Fetch responder with a single-line buffer; misses refill the whole line over
// a req/ack memory port. Option FETCH_PERF_EN adds saturating hit/miss counts.
// Rev    : 1.0
// ============================================================================
module inst_fetch_resp #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [ADDR_W-1:0] pc,
  input  logic              flush,
  output logic [DATA_W-1:0] inst,
  output logic              inst_valid,
  output logic              stallreq,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int OFF_W = IDX_W + 2;
  localparam int TAG_W = ADDR_W - OFF_W;
  localparam logic [IDX_W-1:0] c_last_beat = IDX_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_ABORT = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic              r_line_valid, w_line_valid_nxt;
  logic [TAG_W-1:0]  r_tag, w_tag_nxt;
  logic [TAG_W-1:0]  r_miss_tag, w_miss_tag_nxt;
  logic [IDX_W-1:0]  r_beat, w_beat_nxt, w_beat_inc;
  logic              r_req, w_req_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [DATA_W-1:0] r_buf [LINE_WORDS];

  logic [TAG_W-1:0]  w_tag;
  logic [IDX_W-1:0]  w_idx;
  logic              w_hit;
  logic              w_buf_we;
  logic              w_miss_start;
  logic              w_unused_pc;

  assign w_tag       = pc[ADDR_W-1:OFF_W];
  assign w_idx       = pc[OFF_W-1:2];
  assign w_unused_pc = &{1'b0, pc[1:0]};
  assign w_beat_inc  = r_beat + IDX_W'(1);

  assign w_hit      = ce & r_line_valid & (w_tag == r_tag) & (r_state == S_IDLE);
  assign inst       = w_hit ? r_buf[w_idx] : '0;
  assign inst_valid = w_hit;
  // Gated by rst so a held-off pipeline never sees a stall while in reset.
  assign stallreq   = rst & ce & ~w_hit;
  assign mem_req    = r_req;
  assign mem_addr   = r_addr;

  always_comb begin
    w_state_nxt      = r_state;
    w_line_valid_nxt = r_line_valid;
    w_tag_nxt        = r_tag;
    w_miss_tag_nxt   = r_miss_tag;
    w_beat_nxt       = r_beat;
    w_req_nxt        = r_req;
    w_addr_nxt       = r_addr;
    w_buf_we         = 1'b0;
    w_miss_start     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (flush) begin
          w_line_valid_nxt = 1'b0;
        end else if (ce && !w_hit) begin
          w_miss_tag_nxt = w_tag;
          w_beat_nxt     = '0;
          w_req_nxt      = 1'b1;
          w_addr_nxt     = {w_tag, {OFF_W{1'b0}}};
          w_state_nxt    = S_FILL;
          w_miss_start   = 1'b1;
        end
      end
      S_FILL: begin
        if (mem_ack) begin
          w_buf_we = 1'b1;
          if (flush) begin
            // The beat in flight just landed, so there is nothing left to drain.
            w_req_nxt        = 1'b0;
            w_line_valid_nxt = 1'b0;
            w_beat_nxt       = '0;
            w_state_nxt      = S_IDLE;
          end else if (r_beat == c_last_beat) begin
            w_req_nxt        = 1'b0;
            w_line_valid_nxt = 1'b1;
            w_tag_nxt        = r_miss_tag;
            w_beat_nxt       = '0;
            w_state_nxt      = S_IDLE;
          end else begin
            w_beat_nxt = w_beat_inc;
            // Rebuilding from the tag keeps the walk inside the line at the top of memory.
            w_addr_nxt = {r_miss_tag, w_beat_inc, 2'b00};
          end
        end else if (flush) begin
          w_state_nxt = S_ABORT;
        end
      end
      S_ABORT: begin
        if (mem_ack) begin
          w_req_nxt        = 1'b0;
          w_line_valid_nxt = 1'b0;
          w_beat_nxt       = '0;
          w_state_nxt      = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_line_valid <= 1'b0;
      r_tag        <= '0;
      r_miss_tag   <= '0;
      r_beat       <= '0;
      r_req        <= 1'b0;
      r_addr       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_line_valid <= w_line_valid_nxt;
      r_tag        <= w_tag_nxt;
      r_miss_tag   <= w_miss_tag_nxt;
      r_beat       <= w_beat_nxt;
      r_req        <= w_req_nxt;
      r_addr       <= w_addr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_buf_we) begin
      r_buf[r_beat] <= mem_rdata;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_hit && !flush && (r_hit_cnt != 32'hFFFF_FFFF)) begin
        r_hit_cnt <= r_hit_cnt + 32'd1;
      end
      if (w_miss_start && (r_miss_cnt != 32'hFFFF_FFFF)) begin
        r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_resp.sv
`default_nettype none
// ============================================================================
// Module : tb_inst_fetch_resp
// Self-checking bench for inst_fetch_resp; memory returns addr^A5A50000 after 2 cycles.
// Rev    : 1.0
// ============================================================================
module tb_inst_fetch_resp;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int LINE_WORDS = 4;

  logic              clk   = 1'b0;
  logic              rst   = 1'b0;
  logic              ce    = 1'b0;
  logic              flush = 1'b0;
  logic [ADDR_W-1:0] pc    = '0;
  logic [DATA_W-1:0] inst;
  logic              inst_valid;
  logic              stallreq;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata = '0;
`ifdef FETCH_PERF_EN
  logic [31:0]       hit_cnt;
  logic [31:0]       miss_cnt;
`endif

  logic        mdl_ack   = 1'b0;
  logic        stray_ack = 1'b0;
  logic        ack_high  = 1'b0;
  int          lat_cnt   = 0;
  int          n_checks  = 0;
  int          n_pass    = 0;
  int          beats_seen = 0;
  logic [31:0] sb_exp;
  logic [31:0] exp_q[$];

  inst_fetch_resp #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .LINE_WORDS(LINE_WORDS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .pc        (pc),
    .flush     (flush),
    .inst      (inst),
    .inst_valid(inst_valid),
    .stallreq  (stallreq),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
`ifdef FETCH_PERF_EN
    ,
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  assign mem_ack = mdl_ack | stray_ack;

  // Memory model: ack arrives on the second edge after a request is seen.
  always @(posedge clk) begin
    #2;
    if (!rst) begin
      lat_cnt = 0;
      mdl_ack = 1'b0;
    end else if (ack_high) begin
      mdl_ack = 1'b1;
    end else if (mem_req) begin
      if (lat_cnt == 1) begin
        mdl_ack = 1'b1;
        lat_cnt = 0;
      end else begin
        mdl_ack = 1'b0;
        lat_cnt = lat_cnt + 1;
      end
    end else begin
      mdl_ack = 1'b0;
      lat_cnt = 0;
    end
    mem_rdata = mem_addr ^ 32'hA5A5_0000;
  end

  // Scoreboard: every accepted beat must match the next expected address.
  always @(negedge clk) begin
    if (rst && mem_req && mem_ack) begin
      beats_seen = beats_seen + 1;
      n_checks   = n_checks + 1;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_beat: got unexpected beat at %08h, want none", mem_addr);
      end else begin
        sb_exp = exp_q.pop_front();
        if (mem_addr !== sb_exp) $display("FAIL sb_addr: got %08h want %08h", mem_addr, sb_exp);
        else n_pass = n_pass + 1;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_line(input logic [31:0] base);
    for (int i = 0; i < LINE_WORDS; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  task automatic test_reset();
    int target;
    rst = 1'b0; ce = 1'b1; pc = 32'h10; flush = 1'b0;
    repeat (3) tick();
    n_checks++; if (mem_req !== 1'b0) $display("FAIL rst_mem_req: got %b want 0", mem_req); else n_pass++;
    n_checks++; if (mem_addr !== 32'h0) $display("FAIL rst_mem_addr: got %08h want 0", mem_addr); else n_pass++;
    n_checks++; if (inst !== 32'h0) $display("FAIL rst_inst: got %08h want 0", inst); else n_pass++;
    n_checks++; if (inst_valid !== 1'b0) $display("FAIL rst_inst_valid: got %b want 0", inst_valid); else n_pass++;
    n_checks++; if (stallreq !== 1'b0) $display("FAIL rst_stallreq: got %b want 0", stallreq); else n_pass++;
    rst = 1'b1; pc = 32'h0; #1;
    n_checks++; if (stallreq !== 1'b1) $display("FAIL rel_stallreq: got %b want 1", stallreq); else n_pass++;
    exp_q.push_back(32'h00); exp_q.push_back(32'h04);
    target = beats_seen + 2;
    for (int i = 0; i < 40 && beats_seen < target; i++) tick();
    n_checks++; if (beats_seen !== target) $display("FAIL rst_two_beats: got %0d want %0d", beats_seen, target); else n_pass++;
    tick();
    rst = 1'b0; #1;
    n_checks++; if (mem_req !== 1'b0) $display("FAIL midfill_mem_req: got %b want 0", mem_req); else n_pass++;
    n_checks++; if (inst_valid !== 1'b0) $display("FAIL midfill_inst_valid: got %b want 0", inst_valid); else n_pass++;
    n_checks++; if (stallreq !== 1'b0) $display("FAIL midfill_stallreq: got %b want 0", stallreq); else n_pass++;
    tick();
    rst = 1'b1;
    push_line(32'h0);
    for (int i = 0; i < 40 && !inst_valid; i++) tick();
    n_checks++; if (inst_valid !== 1'b1) $display("FAIL refetch_valid: got %b want 1", inst_valid); else n_pass++;
    n_checks++; if (inst !== 32'hA5A5_0000) $display("FAIL refetch_inst: got %08h want a5a50000", inst); else n_pass++;
  endtask

  task automatic test_cold_miss();
    int n;
    pc = 32'h10; ce = 1'b1; #1;
    n_checks++; if (stallreq !== 1'b1) $display("FAIL cold_stall0: got %b want 1", stallreq); else n_pass++;
    n_checks++; if (mem_req !== 1'b0) $display("FAIL cold_req0: got %b want 0", mem_req); else n_pass++;
    push_line(32'h10);
    n = 1;
    for (int i = 0; i < 40 && stallreq; i++) begin
      tick();
      if (stallreq) n++;
    end
    n_checks++; if (n !== 9) $display("FAIL cold_penalty: got %0d want 9", n); else n_pass++;
    n_checks++; if (inst !== 32'hA5A5_0010) $display("FAIL cold_inst: got %08h want a5a50010", inst); else n_pass++;
    n_checks++; if (inst_valid !== 1'b1) $display("FAIL cold_valid: got %b want 1", inst_valid); else n_pass++;
  endtask

  task automatic test_line_hits();
    logic [31:0] a;
    for (int i = 1; i < LINE_WORDS; i++) begin
      a = 32'h10 + 32'(4 * i);
      pc = a; #1;
      n_checks++; if (inst !== (a ^ 32'hA5A5_0000)) $display("FAIL hit_inst: got %08h want %08h", inst, a ^ 32'hA5A5_0000); else n_pass++;
      n_checks++; if ({inst_valid, stallreq, mem_req} !== 3'b100) $display("FAIL hit_flags: got %b want 100", {inst_valid, stallreq, mem_req}); else n_pass++;
      tick();
    end
    ce = 1'b0; pc = 32'h50; #1;
    n_checks++; if ({inst, inst_valid, stallreq} !== 34'h0) $display("FAIL ce_low_out: got %h want 0", {inst, inst_valid, stallreq}); else n_pass++;
    tick();
    n_checks++; if (mem_req !== 1'b0) $display("FAIL ce_low_req: got %b want 0", mem_req); else n_pass++;
    ce = 1'b1; pc = 32'h20; #1;
    n_checks++; if (stallreq !== 1'b1) $display("FAIL next_miss_stall: got %b want 1", stallreq); else n_pass++;
    push_line(32'h20);
    tick();
    n_checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h20}) $display("FAIL next_miss_req: got %b/%08h want 1/00000020", mem_req, mem_addr); else n_pass++;
    for (int i = 0; i < 40 && !inst_valid; i++) tick();
    n_checks++; if (inst !== 32'hA5A5_0020) $display("FAIL next_miss_inst: got %08h want a5a50020", inst); else n_pass++;
  endtask

  task automatic test_ack_hold();
    int n;
    ack_high = 1'b1; pc = 32'h30;
    push_line(32'h30);
    tick();
    n_checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h30}) $display("FAIL hold_req: got %b/%08h want 1/00000030", mem_req, mem_addr); else n_pass++;
    n = 0;
    for (int i = 0; i < 20 && !inst_valid; i++) begin
      tick();
      n++;
    end
    n_checks++; if (n !== 4) $display("FAIL hold_beats: got %0d cycles want 4", n); else n_pass++;
    n_checks++; if (inst !== 32'hA5A5_0030) $display("FAIL hold_inst: got %08h want a5a50030", inst); else n_pass++;
    ack_high = 1'b0; pc = 32'h34;
    tick();
    stray_ack = 1'b1;
    tick();
    stray_ack = 1'b0; #1;
    n_checks++; if ({mem_req, inst_valid, stallreq} !== 3'b010) $display("FAIL stray_ack_flags: got %b want 010", {mem_req, inst_valid, stallreq}); else n_pass++;
    n_checks++; if (inst !== 32'hA5A5_0034) $display("FAIL stray_ack_inst: got %08h want a5a50034", inst); else n_pass++;
  endtask

  task automatic test_flush_abort();
    int target;
    pc = 32'h40;
    exp_q.push_back(32'h40); exp_q.push_back(32'h44);
    target = beats_seen + 1;
    for (int i = 0; i < 40 && beats_seen < target; i++) tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; #1;
    n_checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h44}) $display("FAIL abort_hold: got %b/%08h want 1/00000044", mem_req, mem_addr); else n_pass++;
    n_checks++; if (stallreq !== 1'b1) $display("FAIL abort_stall: got %b want 1", stallreq); else n_pass++;
    for (int i = 0; i < 20 && mem_req; i++) tick();
    n_checks++; if (mem_req !== 1'b0) $display("FAIL abort_drop: got %b want 0", mem_req); else n_pass++;
    n_checks++; if (inst_valid !== 1'b0) $display("FAIL abort_valid: got %b want 0", inst_valid); else n_pass++;
    push_line(32'h40);
    for (int i = 0; i < 40 && !inst_valid; i++) tick();
    n_checks++; if (inst !== 32'hA5A5_0040) $display("FAIL refill_inst: got %08h want a5a50040", inst); else n_pass++;
    flush = 1'b1; #1;
    n_checks++; if (inst_valid !== 1'b1) $display("FAIL idle_flush_hit: got %b want 1", inst_valid); else n_pass++;
    tick();
    flush = 1'b0; #1;
    n_checks++; if ({mem_req, stallreq} !== 2'b01) $display("FAIL idle_flush_prio: got %b want 01", {mem_req, stallreq}); else n_pass++;
    push_line(32'h40);
    tick();
    n_checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h40}) $display("FAIL idle_flush_miss: got %b/%08h want 1/00000040", mem_req, mem_addr); else n_pass++;
    for (int i = 0; i < 40 && !inst_valid; i++) tick();
    n_checks++; if (inst !== 32'hA5A5_0040) $display("FAIL reflush_inst: got %08h want a5a50040", inst); else n_pass++;
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    rst = 1'b0;
    tick();
    n_checks++; if ({hit_cnt, miss_cnt} !== 64'h0) $display("FAIL perf_rst: got %h want 0", {hit_cnt, miss_cnt}); else n_pass++;
    rst = 1'b1; ce = 1'b1; pc = 32'h10;
    push_line(32'h10);
    for (int i = 0; i < 40 && !inst_valid; i++) tick();
    for (int i = 0; i < LINE_WORDS; i++) begin
      pc = 32'h10 + 32'(4 * i);
      tick();
    end
    pc = 32'h20;
    push_line(32'h20);
    tick();
    n_checks++; if (hit_cnt !== 32'd4) $display("FAIL perf_hits: got %0d want 4", hit_cnt); else n_pass++;
    n_checks++; if (miss_cnt !== 32'd2) $display("FAIL perf_misses: got %0d want 2", miss_cnt); else n_pass++;
    for (int i = 0; i < 40 && !inst_valid; i++) tick();
    dut.r_hit_cnt = 32'hFFFF_FFFF;
    tick();
    tick();
    n_checks++; if (hit_cnt !== 32'hFFFF_FFFF) $display("FAIL perf_sat: got %08h want ffffffff", hit_cnt); else n_pass++;
    ce = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_cold_miss();
    test_line_hits();
    test_ack_hold();
    test_flush_abort();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    repeat (3) tick();
    n_checks++; if (exp_q.size() !== 0) $display("FAIL sb_drain: got %0d pending want 0", exp_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "bench timed out");
  end

endmodule
`default_nettype wire
